// File: rtl/redirect_pkg.sv
// rtl/redirect_pkg.sv - shared types and default widths for the redirect scheduler
package redirect_pkg;

   localparam int PC_W_DEF  = 32;
   localparam int IMM_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      HOLD = 2'd2
   } state_t;

   typedef enum logic {
      SRC_EX = 1'b0,
      SRC_ID = 1'b1
   } src_t;

endpackage

// File: rtl/redirect_target_adder.sv
// rtl/redirect_target_adder.sv - branch target = base + sign-extended immediate, with alignment flag
module redirect_target_adder
   import redirect_pkg::*;
#(
   parameter int PC_W  = PC_W_DEF,
   parameter int IMM_W = IMM_W_DEF
) (
   input  logic [PC_W-1:0]  base,
   input  logic [IMM_W-1:0] imm,
   output logic [PC_W-1:0]  target,
   output logic             aligned
);

   logic [PC_W-1:0] imm_ext;

   // Sign-extend the immediate and add; carry out is dropped so targets wrap through zero
   always_comb begin
      imm_ext = {{(PC_W-IMM_W){imm[IMM_W-1]}}, imm};
      target  = base + imm_ext;
      aligned = (target[1:0] == 2'b00);
   end

endmodule

// File: rtl/redirect_scheduler.sv
// rtl/redirect_scheduler.sv - arbitrates EX/ID redirects onto one target adder and a fetch handshake
module redirect_scheduler
   import redirect_pkg::*;
#(
   parameter int PC_W  = PC_W_DEF,
   parameter int IMM_W = IMM_W_DEF,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ex_valid,
   input  logic             ex_taken,
   input  logic [PC_W-1:0]  ex_pc,
   input  logic [IMM_W-1:0] ex_imm,
   output logic             ex_ready,
   input  logic             id_valid,
   input  logic [PC_W-1:0]  id_pc,
   input  logic [IMM_W-1:0] id_imm,
   output logic             id_ready,
   output logic             redirect_valid,
   output logic [PC_W-1:0]  redirect_pc,
   input  logic             redirect_ready,
   output logic             flush_id,
   output logic             misalign_err,
   output logic [CNT_W-1:0] redirect_count
);

   state_t           state;
   src_t             src;
   logic [PC_W-1:0]  op_pc;
   logic [IMM_W-1:0] op_imm;
   logic [PC_W-1:0]  target;
   logic             aligned;
   logic             ex_redirect;
   logic             preempt;

   redirect_target_adder #(
      .PC_W  (PC_W),
      .IMM_W (IMM_W)
   ) u_adder (
      .base    (op_pc),
      .imm     (op_imm),
      .target  (target),
      .aligned (aligned)
   );

   // Request acceptance: EX is older and always wins; a held ID redirect yields to a taken EX branch
   always_comb begin
      ex_redirect = ex_valid && ex_taken;
      preempt     = (state == HOLD) && (src == SRC_ID) && ex_redirect && !redirect_ready;
      ex_ready    = 1'b0;
      id_ready    = 1'b0;
      case (state)
         IDLE: begin
            ex_ready = 1'b1;
            id_ready = !ex_redirect;
         end
         HOLD: begin
            ex_ready = (ex_valid && !ex_taken) || preempt;
         end
         default: begin
         end
      endcase
   end

   // Scheduler FSM: latch operands, compute target, hold redirect until fetch consumes it
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         src            <= SRC_EX;
         op_pc          <= '0;
         op_imm         <= '0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         flush_id       <= 1'b0;
         misalign_err   <= 1'b0;
         redirect_count <= '0;
      end else begin
         flush_id     <= 1'b0;
         misalign_err <= 1'b0;
         case (state)
            IDLE: begin
               if (ex_redirect) begin
                  op_pc    <= ex_pc;
                  op_imm   <= ex_imm;
                  src      <= SRC_EX;
                  flush_id <= 1'b1;
                  state    <= CALC;
               end else if (id_valid) begin
                  op_pc  <= id_pc;
                  op_imm <= id_imm;
                  src    <= SRC_ID;
                  state  <= CALC;
               end
            end
            CALC: begin
               if (aligned) begin
                  redirect_pc    <= target;
                  redirect_valid <= 1'b1;
                  state          <= HOLD;
               end else begin
                  misalign_err <= 1'b1;
                  state        <= IDLE;
               end
            end
            HOLD: begin
               if (redirect_ready) begin
                  redirect_count <= redirect_count + CNT_W'(1);
                  redirect_valid <= 1'b0;
                  state          <= IDLE;
               end else if (preempt) begin
                  op_pc          <= ex_pc;
                  op_imm         <= ex_imm;
                  src            <= SRC_EX;
                  flush_id       <= 1'b1;
                  redirect_valid <= 1'b0;
                  state          <= CALC;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_redirect_scheduler.sv
// tb/tb_redirect_scheduler.sv - self-checking bench for redirect_scheduler
module tb_redirect_scheduler;

   logic        clk;
   logic        reset;
   logic        ex_valid;
   logic        ex_taken;
   logic [31:0] ex_pc;
   logic [15:0] ex_imm;
   logic        ex_ready;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [15:0] id_imm;
   logic        id_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        redirect_ready;
   logic        flush_id;
   logic        misalign_err;
   logic [15:0] redirect_count;

   int n_assert;
   int n_fail;
   int exp_count;

   redirect_scheduler #(
      .PC_W  (32),
      .IMM_W (16),
      .CNT_W (16)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .ex_valid       (ex_valid),
      .ex_taken       (ex_taken),
      .ex_pc          (ex_pc),
      .ex_imm         (ex_imm),
      .ex_ready       (ex_ready),
      .id_valid       (id_valid),
      .id_pc          (id_pc),
      .id_imm         (id_imm),
      .id_ready       (id_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .redirect_ready (redirect_ready),
      .flush_id       (flush_id),
      .misalign_err   (misalign_err),
      .redirect_count (redirect_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference target: signed arithmetic on wide integers, truncated to 32 bits
   function automatic logic [31:0] ref_target(input logic [31:0] pc, input logic [15:0] imm);
      longint sum;
      sum = longint'(pc) + longint'($signed(imm));
      return sum[31:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present one request in IDLE and walk through the acceptance and calc cycles
   task automatic issue(input bit use_ex, input logic [31:0] pc, input logic [15:0] imm);
      if (use_ex) begin
         ex_valid = 1'b1; ex_taken = 1'b1; ex_pc = pc; ex_imm = imm;
      end else begin
         id_valid = 1'b1; id_pc = pc; id_imm = imm;
      end
      #1;
      if (use_ex) chk1("ex_ready_idle", ex_ready, 1'b1);
      else        chk1("id_ready_idle", id_ready, 1'b1);
      tick();
      ex_valid = 1'b0; ex_taken = 1'b0; id_valid = 1'b0;
      chk1("flush_id_n1", flush_id, use_ex);
      chk1("valid_n1", redirect_valid, 1'b0);
      tick();
   endtask

   // From cycle N+2: check the outcome, hold for 'delay' cycles, then handshake
   task automatic complete(input logic [31:0] t, input int delay);
      chk1("flush_id_n2", flush_id, 1'b0);
      if (t[1:0] != 2'b00) begin
         chk1("misalign_pulse", misalign_err, 1'b1);
         chk1("valid_misalign", redirect_valid, 1'b0);
         tick();
         chk1("misalign_single", misalign_err, 1'b0);
         chk1("valid_after_misalign", redirect_valid, 1'b0);
         chk32("count_misalign", 32'(redirect_count), exp_count & 32'hFFFF);
      end else begin
         chk1("valid_n2", redirect_valid, 1'b1);
         chk32("redirect_pc", redirect_pc, t);
         for (int i = 0; i < delay; i++) begin
            tick();
            chk1("valid_hold", redirect_valid, 1'b1);
            chk32("pc_hold", redirect_pc, t);
         end
         redirect_ready = 1'b1;
         tick();
         redirect_ready = 1'b0;
         exp_count++;
         chk1("valid_after_hs", redirect_valid, 1'b0);
         chk32("count", 32'(redirect_count), exp_count & 32'hFFFF);
      end
   endtask

   initial begin
      logic [31:0] pc;
      logic [15:0] imm;
      bit          use_ex;
      n_assert = 0; n_fail = 0; exp_count = 0;
      reset = 1'b1; ex_valid = 1'b0; ex_taken = 1'b0; ex_pc = '0; ex_imm = '0;
      id_valid = 1'b0; id_pc = '0; id_imm = '0; redirect_ready = 1'b0;
      tick(); tick();
      chk1("rst_valid", redirect_valid, 1'b0);
      chk32("rst_pc", redirect_pc, 32'h0);
      chk1("rst_flush", flush_id, 1'b0);
      chk1("rst_misalign", misalign_err, 1'b0);
      chk32("rst_count", 32'(redirect_count), 32'h0);
      reset = 1'b0;
      tick();

      // EX taken basic
      issue(1'b1, 32'h8000_0000, 16'h1234);
      chk32("ex_basic_pc", redirect_pc, 32'h8000_1234);
      complete(ref_target(32'h8000_0000, 16'h1234), 0);

      // ID only, negative immediate
      issue(1'b0, 32'h8000_0010, 16'h8000);
      chk32("id_neg_pc", redirect_pc, 32'h7FFF_8010);
      complete(ref_target(32'h8000_0010, 16'h8000), 2);

      // Wrap through zero
      issue(1'b1, 32'hFFFF_FFFC, 16'h0008);
      chk32("wrap_pc", redirect_pc, 32'h0000_0004);
      complete(ref_target(32'hFFFF_FFFC, 16'h0008), 1);

      // Misaligned target
      issue(1'b0, 32'h8000_0004, 16'hFFFF);
      complete(ref_target(32'h8000_0004, 16'hFFFF), 0);
      chk32("pc_kept_after_misalign", redirect_pc, 32'h0000_0004);

      // Preemption of a held ID redirect by a taken EX branch
      issue(1'b0, 32'h8000_0100, 16'h0000);
      chk32("preempt_id_pc", redirect_pc, 32'h8000_0100);
      tick();
      chk1("preempt_id_held", redirect_valid, 1'b1);
      ex_valid = 1'b1; ex_taken = 1'b1; ex_pc = 32'h8000_0000; ex_imm = 16'h0040;
      #1;
      chk1("preempt_ex_ready", ex_ready, 1'b1);
      chk1("preempt_id_ready", id_ready, 1'b0);
      tick();
      ex_valid = 1'b0; ex_taken = 1'b0;
      chk1("preempt_flush", flush_id, 1'b1);
      chk1("preempt_valid_drop", redirect_valid, 1'b0);
      chk32("preempt_count_unchanged", 32'(redirect_count), exp_count & 32'hFFFF);
      tick();
      complete(32'h8000_0040, 0);

      // Simultaneous EX taken and ID in IDLE: EX wins
      ex_valid = 1'b1; ex_taken = 1'b1; ex_pc = 32'h0000_1000; ex_imm = 16'h0010;
      id_valid = 1'b1; id_pc = 32'h0000_2000; id_imm = 16'h0020;
      #1;
      chk1("simul_ex_ready", ex_ready, 1'b1);
      chk1("simul_id_ready", id_ready, 1'b0);
      tick();
      ex_valid = 1'b0; ex_taken = 1'b0; id_valid = 1'b0;
      chk1("simul_flush", flush_id, 1'b1);
      tick();
      complete(32'h0000_1010, 0);

      // Not-taken EX alongside ID: ID is granted, no flush
      ex_valid = 1'b1; ex_taken = 1'b0; ex_pc = 32'h0000_3000; ex_imm = 16'h0004;
      id_valid = 1'b1; id_pc = 32'h0000_4000; id_imm = 16'h0008;
      #1;
      chk1("nt_ex_ready", ex_ready, 1'b1);
      chk1("nt_id_ready", id_ready, 1'b1);
      tick();
      ex_valid = 1'b0; id_valid = 1'b0;
      chk1("nt_flush", flush_id, 1'b0);
      tick();
      complete(32'h0000_4008, 0);

      // Reset while holding a redirect
      issue(1'b1, 32'h0000_0100, 16'h0100);
      chk1("rst_hold_valid_pre", redirect_valid, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_count = 0;
      chk1("rst_hold_valid", redirect_valid, 1'b0);
      chk32("rst_hold_count", 32'(redirect_count), 32'h0);
      chk32("rst_hold_pc", redirect_pc, 32'h0);
      tick();

      // Randomized requests against the reference target model
      for (int n = 0; n < 40; n++) begin
         use_ex = 1'($urandom_range(0, 1));
         pc     = $urandom();
         imm    = 16'($urandom_range(0, 65535));
         if ($urandom_range(0, 3) != 0) begin
            pc[1:0]  = 2'b00;
            imm[1:0] = 2'b00;
         end
         issue(use_ex, pc, imm);
         complete(ref_target(pc, imm), int'($urandom_range(0, 3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/redirect_scheduler.md
Name: redirect_scheduler

Overview:
Arbitrates two front-end redirect requesters for one branch-target adder: the execute-stage branch unit (EX) and the decode-stage jump unit (ID). It sequences the adder, checks target alignment, and presents one registered redirect PC to fetch under a valid/ready handshake. It sits between EX/ID and the fetch PC mux. EX is older and always wins; a taken EX branch squashes any younger ID request.

Parameters:
PC_W, 32, program counter / target width
IMM_W, 16, immediate width, sign-extended to PC_W
CNT_W, 16, redirect counter width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
ex_valid  in  1  EX branch resolved this cycle
ex_taken  in  1  EX branch taken
ex_pc  in  PC_W  EX branch base PC
ex_imm  in  IMM_W  EX branch immediate
ex_ready  out  1  EX request accepted when ex_valid&&ex_ready
id_valid  in  1  ID jump request
id_pc  in  PC_W  ID jump base PC
id_imm  in  IMM_W  ID jump immediate
id_ready  out  1  ID request accepted when id_valid&&id_ready
redirect_valid  out  1  redirect_pc valid for fetch
redirect_pc  out  PC_W  target PC
redirect_ready  in  1  fetch consumes redirect
flush_id  out  1  one-cycle pulse: squash decode
misalign_err  out  1  one-cycle pulse: computed target[1:0]!=0
redirect_count  out  CNT_W  completed redirect handshakes

Behaviour:
- Target = base_pc + sign_extend(imm) modulo 2^PC_W (no scaling, carry out discarded, wraps through 0).
- States: IDLE, CALC, HOLD.
- Reset: state IDLE; redirect_valid, redirect_pc, flush_id, misalign_err, redirect_count all 0. Reset in any state drops a pending or held redirect.
- IDLE: ex_ready=1, id_ready=!(ex_valid&&ex_taken).
  - ex_valid&&ex_taken: latch ex_pc/ex_imm, src=EX, flush_id=1 next cycle, go CALC.
  - ex_valid&&!ex_taken: accepted, no redirect, stay IDLE. A same-cycle id_valid is then granted.
  - else id_valid: latch id operands, src=ID, go CALC.
- CALC: ex_ready=id_ready=0. Adder runs on latched operands. Register result into redirect_pc.
  - Aligned target: go HOLD.
  - Misaligned target: misalign_err=1 next cycle, redirect_pc unchanged, go IDLE.
- HOLD: redirect_valid=1, redirect_pc stable.
  - redirect_ready: increment redirect_count (wraps), go IDLE. id_ready=0 and ex_ready=0 this cycle; a new request waits for IDLE.
  - Preemption: src=ID and ex_valid&&ex_taken with no redirect_ready this cycle. ex_ready=1, EX operands latched, flush_id pulse, go CALC, redirect_valid drops next cycle. The ID redirect is discarded and not counted.
  - src=EX: ex_ready=0.
  - ex_valid&&!ex_taken: ex_ready=1 in HOLD always (no effect).
- Latency: request accepted in cycle N, redirect_valid high from N+2 until the handshake.
- flush_id and misalign_err are registered single-cycle pulses.

Decomposition:
- Package redirect_pkg: state enum (IDLE/CALC/HOLD), src enum (SRC_EX/SRC_ID), PC_W/IMM_W defaults.
- One sub-module, redirect_target_adder: combinational base + sign-extended imm, plus an aligned flag. Instantiated once inside the scheduler.

Test Plan:
- EX taken, ex_pc=0x80000000, ex_imm=0x1234, redirect_ready=1 -> flush_id pulse at N+1; redirect_valid at N+2 with redirect_pc=0x80001234; redirect_count=1.
- ID only, id_pc=0x80000010, id_imm=0x8000 -> redirect_pc=0x7FFF8010; flush_id stays 0.
- Wrap: ex_pc=0xFFFFFFFC, ex_imm=0x0008 -> redirect_pc=0x00000004.
- Misalign: id_pc=0x80000004, id_imm=0xFFFF -> misalign_err pulse; redirect_valid never asserts; count unchanged.
- Preempt: ID redirect 0x80000100 held with redirect_ready=0, then EX taken pc=0x80000000 imm=0x0040 -> ex_ready=1, flush_id pulse; final redirect_pc=0x80000040; exactly one handshake counted.
- Simultaneous EX taken and ID in IDLE -> id_ready=0, EX granted. Reset asserted in HOLD -> next cycle redirect_valid=0, count=0.
